// File: rtl/dmem_mmio_if.sv
// Core data-port and TX byte-stream signals for the dmem_mmio stage.
// The master is the core/consumer side; the slave is the memory stage.
interface dmem_mmio_if;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output memwrite, aluout, writedata, tx_ready,
    input  readdata, tx_valid, tx_data
  );

  modport slave (
    input  memwrite, aluout, writedata, tx_ready,
    output readdata, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data memory stage: word RAM with combinational read, plus an MMIO page holding
// a TX byte FIFO (valid/ready drain) and a sticky-overflow status register.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  dmem_mmio_if.slave  bus
);
  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;

  logic [31:0]   r_ram  [RAM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_mmio;
  logic          w_txdata_hit;
  logic          w_status_hit;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [AW-1:0] w_ram_idx;
  logic [31:0]   w_status;

  assign w_mmio       = (bus.aluout[31:16] == 16'hFFFF);
  assign w_txdata_hit = w_mmio && (bus.aluout[15:0] == OFF_TXDATA);
  assign w_status_hit = w_mmio && (bus.aluout[15:0] == OFF_STATUS);
  assign w_ram_idx    = bus.aluout[AW+1:2];

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_pop      = bus.tx_valid && bus.tx_ready;
  assign w_push_req = bus.memwrite && w_txdata_hit;
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = bus.memwrite && w_status_hit && bus.writedata[9];

  assign w_status = {22'b0, r_ovf, w_full, 8'(r_count)};

  always_comb begin
    bus.readdata = 32'h0;
    if (!w_mmio)           bus.readdata = r_ram[w_ram_idx];
    else if (w_status_hit) bus.readdata = w_status;
  end

  assign bus.tx_valid = (r_count != '0);
  assign bus.tx_data  = bus.tx_valid ? r_fifo[r_rd_ptr] : 8'h00;

  // RAM and FIFO storage are not reset; only the control state is.
  always_ff @(posedge clk) begin
    if (bus.memwrite && !w_mmio) r_ram[w_ram_idx] <= bus.writedata;
    if (w_push)                  r_fifo[r_wr_ptr] <= bus.writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed, table-driven bench for dmem_mmio (RAM_WORDS=64, FIFO_DEPTH=8).
module tb_dmem_mmio;
  localparam logic [31:0] A_TX = 32'hFFFF_0000;
  localparam logic [31:0] A_ST = 32'hFFFF_0004;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  dmem_mmio_if bus ();

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] rd;
    logic        v;
    logic [7:0]  d;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic rdy, input logic chk_rd, input logic [31:0] rd,
                     input logic v, input logic [7:0] d);
    vec_t t;
    t.we = we; t.addr = addr; t.wd = wd; t.rdy = rdy;
    t.chk_rd = chk_rd; t.rd = rd; t.v = v; t.d = d;
    vq.push_back(t);
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rdy);
    bus.memwrite  = we;
    bus.aluout    = addr;
    bus.writedata = wd;
    bus.tx_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, A_ST, 32'h0, 1'b0);
    reset_n = 1'b0;
    #12;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_status", bus.readdata, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // RAM store, load and aliasing
    add(1, 32'h10, 32'h12345678, 0, 0, 32'h0, 0, 8'h00);
    add(0, 32'h10, 32'h0, 0, 1, 32'h12345678, 0, 8'h00);
    add(0, 32'h110, 32'h0, 0, 1, 32'h12345678, 0, 8'h00);
    add(0, 32'h13, 32'h0, 0, 1, 32'h12345678, 0, 8'h00);
    add(0, 32'hFFFF_0008, 32'h0, 0, 1, 32'h0, 0, 8'h00);
    add(0, A_TX, 32'h0, 0, 1, 32'h0, 0, 8'h00);
    // three pushes held, then drained in order
    add(1, A_TX, 32'h41, 0, 1, 32'h0, 0, 8'h00);
    add(1, A_TX, 32'h42, 0, 1, 32'h0, 1, 8'h41);
    add(1, A_TX, 32'h43, 0, 1, 32'h0, 1, 8'h41);
    add(0, A_ST, 32'h0, 0, 1, 32'h003, 1, 8'h41);
    add(0, A_ST, 32'h0, 1, 1, 32'h003, 1, 8'h41);
    add(0, A_ST, 32'h0, 1, 1, 32'h002, 1, 8'h42);
    add(0, A_ST, 32'h0, 1, 1, 32'h001, 1, 8'h43);
    add(0, A_ST, 32'h0, 0, 1, 32'h000, 0, 8'h00);
    // nine pushes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++)
      add(1, A_TX, 32'(i), 0, 1, 32'h0, (i > 1), (i > 1) ? 8'h01 : 8'h00);
    add(0, A_ST, 32'h0, 0, 1, 32'h308, 1, 8'h01);
    add(1, A_ST, 32'h0, 0, 1, 32'h308, 1, 8'h01);
    add(0, A_ST, 32'h0, 0, 1, 32'h308, 1, 8'h01);
    add(1, A_ST, 32'h200, 0, 1, 32'h308, 1, 8'h01);
    add(0, A_ST, 32'h0, 0, 1, 32'h108, 1, 8'h01);
    // push while full with a simultaneous pop
    add(1, A_TX, 32'h55, 1, 1, 32'h0, 1, 8'h01);
    add(0, A_ST, 32'h0, 0, 1, 32'h108, 1, 8'h02);
    for (int k = 0; k < 8; k++)
      add(0, A_ST, 32'h0, 1, 1, (k == 0) ? 32'h108 : 32'(8 - k), 1,
          (k == 7) ? 8'h55 : 8'(k + 2));
    add(0, A_ST, 32'h0, 0, 1, 32'h000, 0, 8'h00);

    foreach (vq[i]) begin
      drive(vq[i].we, vq[i].addr, vq[i].wd, vq[i].rdy);
      #1;
      if (vq[i].chk_rd) check($sformatf("v%0d_readdata", i), bus.readdata, vq[i].rd);
      check($sformatf("v%0d_tx_valid", i), 32'(bus.tx_valid), 32'(vq[i].v));
      check($sformatf("v%0d_tx_data", i), 32'(bus.tx_data), 32'(vq[i].d));
      tick();
    end

    // reset mid-drain discards the queue but keeps RAM
    drive(1, A_TX, 32'hA1, 0); tick();
    drive(1, A_TX, 32'hA2, 0); tick();
    drive(1, A_TX, 32'hA3, 0); tick();
    drive(0, A_ST, 32'h0, 1);  tick();
    drive(0, A_ST, 32'h0, 0);
    #1;
    check("pre_rst_status", bus.readdata, 32'h002);
    check("pre_rst_tx_data", 32'(bus.tx_data), 32'hA2);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("mid_rst_status", bus.readdata, 32'h0);
    tick();
    reset_n = 1'b1;
    drive(0, 32'h10, 32'h0, 0);
    #1;
    check("post_rst_ram", bus.readdata, 32'h12345678);
    tick();
    drive(1, A_TX, 32'hB7, 0);
    #1;
    check("post_rst_empty", 32'(bus.tx_valid), 32'h0);
    tick();
    drive(0, A_ST, 32'h0, 0);
    #1;
    check("post_rst_push_valid", 32'(bus.tx_valid), 32'h1);
    check("post_rst_push_data", 32'(bus.tx_data), 32'hB7);
    check("post_rst_status", bus.readdata, 32'h001);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
